dice_roll_engine: RTL and testbench

//  Consumes the 3-bit die code from the button encoder plus a debounced ROLL button.

---
 rtl/dice_roll_engine.sv | 130 +++++++++++++
 tb/tb_dice_roll_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_engine.sv
// Die roller: a synchronised ROLL edge starts a tumble driven by a free-running LFSR,
// then settles on a uniformly distributed 1..N value using rejection sampling.
module dice_roll_engine #(
    parameter int          ROLL_CYCLES = 32,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] dieSelect,
    input  logic       roll_btn,
    output logic [4:0] result,
    output logic       result_valid,
    output logic       rolling,
    output logic [4:0] die_sides
);

    localparam int TC_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ROLL, SETTLE, DONE} state_t;

    state_t          state_q;
    logic [15:0]     lfsr_q;
    logic [15:0]     lfsr_d;
    logic            s1_q;
    logic            s2_q;
    logic            sprev_q;
    logic            rise;
    logic [TC_W-1:0] tc_q;
    logic [4:0]      test_cnt_q;
    logic [4:0]      result_q;
    logic [4:0]      sides_q;
    logic            valid_q;
    logic            rolling_q;
    logic [5:0]      cand;
    logic            ok;

    function automatic logic [4:0] sides_of(input logic [2:0] code);
        logic [4:0] s;
        case (code)
            3'b000:  s = 5'd4;
            3'b001:  s = 5'd6;
            3'b010:  s = 5'd8;
            3'b011:  s = 5'd10;
            3'b100:  s = 5'd12;
            default: s = 5'd20;
        endcase
        return s;
    endfunction

    // Taps 16,14,13,11 expressed for a right-shifting register.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        cand   = {1'b0, lfsr_q[4:0]} + 6'd1;
        ok     = (cand <= {1'b0, sides_q});
        rise   = s2_q & ~sprev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= LFSR_SEED;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            sprev_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            s1_q    <= roll_btn;
            s2_q    <= s1_q;
            sprev_q <= s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tc_q       <= '0;
            test_cnt_q <= 5'd1;
            result_q   <= '0;
            sides_q    <= '0;
            valid_q    <= 1'b0;
            rolling_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (rise) begin
                        if (dieSelect[2:1] == 2'b11) begin
                            sides_q    <= 5'd20;
                            result_q   <= test_cnt_q;
                            valid_q    <= 1'b1;
                            test_cnt_q <= (test_cnt_q == 5'd20) ? 5'd1 : test_cnt_q + 5'd1;
                            rolling_q  <= 1'b0;
                            state_q    <= DONE;
                        end else begin
                            sides_q   <= sides_of(dieSelect);
                            valid_q   <= 1'b0;
                            tc_q      <= TC_W'(ROLL_CYCLES - 1);
                            rolling_q <= 1'b1;
                            state_q   <= ROLL;
                        end
                    end
                end
                ROLL: begin
                    if (ok) begin
                        result_q <= cand[4:0];
                    end
                    if (tc_q == '0) begin
                        state_q <= SETTLE;
                    end else begin
                        tc_q <= tc_q - TC_W'(1);
                    end
                end
                SETTLE: begin
                    // Rejected candidates just wait for the next LFSR step.
                    if (ok) begin
                        result_q  <= cand[4:0];
                        valid_q   <= 1'b1;
                        rolling_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result       = result_q;
    assign result_valid = valid_q;
    assign rolling      = rolling_q;
    assign die_sides    = sides_q;

endmodule

// File: tb/tb_dice_roll_engine.sv
// Scoreboard bench for dice_roll_engine: the stimulus side predicts each settled value
// and its edge from an LFSR model; a negedge monitor pops and compares on every new output.
module tb_dice_roll_engine;

    localparam int          RC   = 32;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] dieSelect;
    logic       roll_btn;
    logic [4:0] result;
    logic       result_valid;
    logic       rolling;
    logic [4:0] die_sides;

    always #5 clk = ~clk;

    dice_roll_engine #(.ROLL_CYCLES(RC), .LFSR_SEED(SEED)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dieSelect    (dieSelect),
        .roll_btn     (roll_btn),
        .result       (result),
        .result_valid (result_valid),
        .rolling      (rolling),
        .die_sides    (die_sides)
    );

    typedef struct {
        logic [4:0]  value;
        logic [4:0]  sides;
        int unsigned at_edge;
    } exp_t;

    exp_t        sb[$];
    exp_t        head;
    int          checks = 0;
    int          errors = 0;
    int unsigned ecount;
    logic        prev_valid = 1'b0;
    logic [4:0]  prev_result = 5'd0;
    logic [4:0]  last_result = 5'd0;
    logic [4:0]  cur_sides = 5'd0;
    logic [4:0]  tcnt = 5'd1;
    logic [4:0]  r_first;
    logic [3:0]  seen = 4'd0;
    bit          tumble_chk = 1'b0;
    bit          track_seen = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // LFSR contents seen by the design at edge e (edge 1 is the first after reset release).
    function automatic logic [15:0] lfsr_at(input int unsigned e);
        logic [15:0] v = SEED;
        for (int unsigned i = 1; i < e; i++) v = lfsr_step(v);
        return v;
    endfunction

    function automatic logic [4:0] exp_sides(input logic [2:0] sel);
        case (sel)
            3'd0:    return 5'd4;
            3'd1:    return 5'd6;
            3'd2:    return 5'd8;
            3'd3:    return 5'd10;
            3'd4:    return 5'd12;
            default: return 5'd20;
        endcase
    endfunction

    // Monitor: a new output is a valid rise or a changed value while valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (result_valid && (!prev_valid || result != prev_result)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: result %0d appeared with nothing expected", result);
                end else begin
                    head = sb.pop_front();
                    check("result", 32'(result), 32'(head.value));
                    check("die_sides", 32'(die_sides), 32'(head.sides));
                    check("valid_edge", ecount, head.at_edge);
                    check("rolling_low_when_valid", 32'(rolling), 32'd0);
                end
                last_result = result;
                if (track_seen && result >= 5'd1 && result <= 5'd4)
                    seen[result[1:0] - 2'd1] = 1'b1;
            end
            if (tumble_chk && rolling)
                check("tumble_range", 32'(result <= cur_sides), 32'd1);
        end
        prev_valid  = result_valid;
        prev_result = result;
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_rolling"}, 32'(rolling), 32'd0);
        check({tag, "_die_sides"}, 32'(die_sides), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs(tag);
        sb.delete();
        tcnt = 5'd1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_roll(input logic [2:0] sel, input bit disturb, input logic [2:0] sel_mid);
        int unsigned n, r, e, guard, rc_cnt;
        logic [4:0]  s;
        logic [15:0] v;
        logic [5:0]  c;
        @(negedge clk);
        dieSelect = sel;
        roll_btn  = 1'b1;
        n = ecount;
        r = n + 3;
        s = exp_sides(sel);
        cur_sides = s;
        e = r + RC + 1;
        v = lfsr_at(e);
        c = {1'b0, v[4:0]} + 6'd1;
        for (int k = 0; k < 4000 && c > {1'b0, s}; k++) begin
            v = lfsr_step(v);
            e++;
            c = {1'b0, v[4:0]} + 6'd1;
        end
        sb.push_back('{value: c[4:0], sides: s, at_edge: e});
        repeat (2) @(negedge clk);
        roll_btn = 1'b0;
        repeat (2) @(negedge clk);
        check("rolling_in_roll", 32'(rolling), 32'd1);
        check("sides_latched", 32'(die_sides), 32'(s));
        rc_cnt = 1;
        if (disturb) begin
            dieSelect = sel_mid;
            roll_btn  = 1'b1;
            repeat (3) @(negedge clk);
            roll_btn = 1'b0;
        end
        guard = 0;
        while (ecount < e + 1 && guard < 6000) begin
            @(negedge clk);
            guard++;
            if (rolling) rc_cnt++;
        end
        check("roll_completed", 32'(sb.size()), 32'd0);
        if (!disturb) check("rolling_cycles_ge_rc", 32'(rc_cnt >= RC), 32'd1);
    endtask

    task automatic test_pulse(input logic [2:0] sel);
        int unsigned n;
        @(negedge clk);
        dieSelect = sel;
        roll_btn  = 1'b1;
        n = ecount;
        sb.push_back('{value: tcnt, sides: 5'd20, at_edge: n + 3});
        tcnt = (tcnt == 5'd20) ? 5'd1 : tcnt + 5'd1;
        @(negedge clk);
        roll_btn = 1'b0;
        repeat (2) @(negedge clk);
        check("test_rolling_low", 32'(rolling), 32'd0);
        check("test_valid_now", 32'(result_valid), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        roll_btn  = 1'b0;
        dieSelect = 3'b000;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // First D4 roll at a fixed offset from reset, kept for the reproducibility check.
        while (ecount < 4) @(negedge clk);
        do_roll(3'b000, 1'b0, 3'b000);
        r_first = last_result;

        for (int sel = 0; sel < 6; sel++) do_roll(3'(sel), 1'b0, 3'b000);

        do_roll(3'b001, 1'b1, 3'b101);
        check("sides_after_disturb", 32'(die_sides), 32'd6);
        check("result_le_6", 32'(result <= 5'd6), 32'd1);

        do_roll(3'b101, 1'b0, 3'b000);

        // Abort a D4 roll mid-tumble, then repeat the first roll at the same offset.
        @(negedge clk);
        dieSelect = 3'b000;
        roll_btn  = 1'b1;
        repeat (2) @(negedge clk);
        roll_btn = 1'b0;
        repeat (10) @(negedge clk);
        check("aborted_roll_rolling", 32'(rolling), 32'd1);
        do_reset("midroll");
        while (ecount < 4) @(negedge clk);
        do_roll(3'b000, 1'b0, 3'b000);
        check("repro_after_reset", 32'(last_result), 32'(r_first));

        do_reset("pretest");
        for (int i = 0; i < 21; i++) test_pulse((i % 2 == 0) ? 3'b111 : 3'b110);
        check("test_seq_drained", 32'(sb.size()), 32'd0);
        check("test_final_value", 32'(result), 32'd1);

        track_seen = 1'b1;
        tumble_chk = 1'b1;
        for (int i = 0; i < 200; i++) do_roll(3'b000, 1'b0, 3'b000);
        tumble_chk = 1'b0;
        check("d4_all_values_seen", 32'(seen), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
